// File: rtl/cpu_bus_seq.sv
// cpu_bus_seq: bus-cycle sequencer feeding the cpu_bus tm/ad encoder
// Walks each CPU request through CHECK / ADDR / DATA / TURN and returns ack, err and read data.
// Optional DATA-state timeout is built when XIBUS_TIMEOUT_EN is defined.
module cpu_bus_seq #(
    parameter int ADDR_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [3:0]  cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        adrcyn_o,
    output logic [3:0]  enc_write_o,
    output logic [31:0] enc_addr_o,
    output logic [31:0] enc_wdata_o,
    input  logic        enc_err_i,
    output logic        bus_oe_o,
    output logic        dsn_o,
    input  logic        rdyn_i,
    input  logic [31:0] bus_ad_i
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;
    localparam int ACW = ADDR_CYCLES > 1 ? $clog2(ADDR_CYCLES) : 1;
    logic [2:0]     state;
    logic [2:0]     nxt;
    logic [ACW-1:0] acnt;
    logic           err_set;
    logic           to_hit;
`ifdef XIBUS_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TCW-1:0] tcnt;
    // Count DATA cycles spent waiting on a not-ready target; idle at zero elsewhere
    always_ff @(posedge clk) begin
        if (rst)
            tcnt <= '0;
        else
            tcnt <= state != S_DATA || nxt != S_DATA ? '0 : rdyn_i ? tcnt + TCW'(1) : tcnt;
    end
    assign to_hit = state == S_DATA && rdyn_i && tcnt == TCW'(TIMEOUT_CYCLES - 1);
`else
    assign to_hit = 1'b0;
`endif
    // Next-state decode; err_set marks transitions into TURN that must report an error
    always_comb begin
        nxt     = state;
        err_set = 1'b0;
        case (state)
            S_IDLE:  nxt = cpu_req ? S_CHECK : S_IDLE;
            S_CHECK: begin
                nxt     = enc_err_i ? S_TURN : S_ADDR;
                err_set = enc_err_i;
            end
            S_ADDR:  nxt = acnt == ACW'(ADDR_CYCLES - 1) ? S_DATA : S_ADDR;
            S_DATA:  begin
                nxt     = !rdyn_i || to_hit ? S_TURN : S_DATA;
                err_set = to_hit;
            end
            S_TURN:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end
    // State register and address-phase length counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acnt  <= '0;
        end else begin
            state <= nxt;
            acnt  <= state == S_ADDR && nxt == S_ADDR ? acnt + ACW'(1) : '0;
        end
    end
    // Bus control and handshake outputs are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            adrcyn_o <= 1'b1;
            dsn_o    <= 1'b1;
            bus_oe_o <= 1'b0;
            cpu_ack  <= 1'b0;
            cpu_err  <= 1'b0;
        end else begin
            adrcyn_o <= nxt != S_ADDR;
            dsn_o    <= nxt != S_DATA;
            bus_oe_o <= nxt == S_ADDR || (nxt == S_DATA && |enc_write_o);
            cpu_ack  <= nxt == S_TURN;
            cpu_err  <= nxt == S_TURN && err_set;
        end
    end
    // Latch the request fields in IDLE; capture read data on the ready edge, zero it on timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_write_o <= '0;
            enc_addr_o  <= '0;
            enc_wdata_o <= '0;
            cpu_rdata   <= '0;
        end else begin
            if (state == S_IDLE && cpu_req) begin
                enc_write_o <= cpu_write;
                enc_addr_o  <= cpu_addr;
                enc_wdata_o <= cpu_wdata;
            end
            if (to_hit)
                cpu_rdata <= '0;
            else if (state == S_DATA && !rdyn_i && enc_write_o == 4'b0000)
                cpu_rdata <= bus_ad_i;
        end
    end
endmodule

// File: tb/tb_cpu_bus_seq.sv
// tb_cpu_bus_seq: randomized self-checking bench for cpu_bus_seq against a transaction-level model
module tb_cpu_bus_seq;
    localparam int AC = 2;
`ifdef XIBUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 1 << 30;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [3:0]  cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic        adrcyn_o;
    logic [3:0]  enc_write_o;
    logic [31:0] enc_addr_o;
    logic [31:0] enc_wdata_o;
    logic        enc_err_i;
    logic        bus_oe_o;
    logic        dsn_o;
    logic        rdyn_i;
    logic [31:0] bus_ad_i;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rdata = '0;
    int          o_ack, o_adr, o_dsn, o_oe, o_bad;
    logic        o_err;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_wr;
    always #5 clk = ~clk;
    cpu_bus_seq #(.ADDR_CYCLES(AC), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .adrcyn_o(adrcyn_o),
        .enc_write_o(enc_write_o), .enc_addr_o(enc_addr_o), .enc_wdata_o(enc_wdata_o),
        .enc_err_i(enc_err_i), .bus_oe_o(bus_oe_o), .dsn_o(dsn_o),
        .rdyn_i(rdyn_i), .bus_ad_i(bus_ad_i)
    );
    // Encoder accepts a read, single bytes, aligned halves and full words
    function automatic logic legal(input logic [3:0] s);
        return s inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction
    assign enc_err_i = !legal(enc_write_o);
    // Transaction-level expectation: cycle counts from the request cycle, and the read-data history
    task automatic predict(input logic [3:0] s, input logic [31:0] ad, input int w,
                           output int e_ack, output int e_dsn, output int e_oe, output logic e_err);
        bit tmo;
        tmo = w >= TO;
        if (!legal(s)) begin
            e_ack = 2;
            e_dsn = 0;
            e_oe  = 0;
            e_err = 1'b1;
        end else begin
            e_dsn = tmo ? TO : w + 1;
            e_ack = 1 + AC + e_dsn + 1;
            e_oe  = AC + (s != 4'b0000 ? e_dsn : 0);
            e_err = tmo;
            if (tmo)
                model_rdata = '0;
            else if (s == 4'b0000)
                model_rdata = ad;
        end
    endtask
    // Master plus target: issues one request, makes the target ready on DATA cycle w+1, records what it sees
    task automatic drive_txn(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] ad, input int w, input bit hold, input int limit);
        int c;
        int k;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_write = s;
        cpu_addr = a;
        cpu_wdata = d;
        c = 0;
        k = 0;
        o_ack = -1;
        o_adr = 0;
        o_dsn = 0;
        o_oe = 0;
        o_bad = 0;
        while (o_ack < 0 && c < limit) begin
            @(negedge clk);
            c++;
            if (!adrcyn_o) o_adr++;
            if (bus_oe_o) o_oe++;
            if (bus_oe_o && adrcyn_o && dsn_o) o_bad++;
            if (!dsn_o) begin
                o_dsn++;
                k++;
                rdyn_i = k != w + 1;
                bus_ad_i = rdyn_i ? $urandom : ad;
            end else begin
                rdyn_i = $urandom_range(0, 1) == 1;
                bus_ad_i = $urandom;
            end
            if (cpu_ack) begin
                o_ack = c;
                o_err = cpu_err;
                o_rdata = cpu_rdata;
                o_wr = enc_write_o;
                o_addr = enc_addr_o;
                o_wdata = enc_wdata_o;
                if (!hold) cpu_req = 1'b0;
            end
        end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_write = 4'hF;
        cpu_addr = 32'hFFFF_FFFF;
        cpu_wdata = 32'hFFFF_FFFF;
        rdyn_i = 1'b1;
        bus_ad_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({adrcyn_o, dsn_o, bus_oe_o, cpu_ack, cpu_err} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 11000", {adrcyn_o, dsn_o, bus_oe_o, cpu_ack, cpu_err});
        end
        checks++;
        if (cpu_rdata !== 32'h0 || enc_addr_o !== 32'h0 || enc_wdata_o !== 32'h0 || enc_write_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_regs: rdata=%h addr=%h wdata=%h wr=%b want all zero",
                     cpu_rdata, enc_addr_o, enc_wdata_o, enc_write_o);
        end
        rst = 1'b0;
    endtask
    task automatic test_read;
        int e_ack, e_dsn, e_oe;
        logic e_err;
        predict(4'b0000, 32'hCAFE_BABE, 0, e_ack, e_dsn, e_oe, e_err);
        drive_txn(4'b0000, 32'h0000_1000, 32'h0, 32'hCAFE_BABE, 0, 1'b0, 50);
        checks++;
        if (o_ack !== 5) begin errors++; $display("FAIL read_latency: got %0d want 5", o_ack); end
        checks++;
        if (o_adr !== 2) begin errors++; $display("FAIL read_adrcyn_len: got %0d want 2", o_adr); end
        checks++;
        if (o_rdata !== 32'hCAFE_BABE || o_err !== 1'b0) begin
            errors++;
            $display("FAIL read_data: got %h err=%b want cafebabe err=0", o_rdata, o_err);
        end
        checks++;
        if (o_addr !== 32'h0000_1000 || o_oe !== e_oe) begin
            errors++;
            $display("FAIL read_addr_oe: addr=%h oe=%0d want 00001000 oe=%0d", o_addr, o_oe, e_oe);
        end
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: ack=%b want 0", cpu_ack); end
    endtask
    task automatic test_write;
        int e_ack, e_dsn, e_oe;
        logic e_err;
        predict(4'b0011, 32'h0, 0, e_ack, e_dsn, e_oe, e_err);
        drive_txn(4'b0011, 32'h20, 32'h1234, 32'h5555_AAAA, 0, 1'b0, 50);
        checks++;
        if (o_wr !== 4'b0011 || o_addr !== 32'h20 || o_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL write_enc: wr=%b addr=%h wdata=%h want 0011 00000020 00001234", o_wr, o_addr, o_wdata);
        end
        checks++;
        if (o_oe !== e_oe || o_bad !== 0) begin
            errors++;
            $display("FAIL write_oe: oe=%0d bad=%0d want %0d 0", o_oe, o_bad, e_oe);
        end
        checks++;
        if (o_ack !== e_ack || o_err !== 1'b0 || o_rdata !== model_rdata) begin
            errors++;
            $display("FAIL write_ack: ack=%0d err=%b rdata=%h want %0d 0 %h", o_ack, o_err, o_rdata, e_ack, model_rdata);
        end
    endtask
    task automatic test_illegal;
        drive_txn(4'b0101, 32'h44, 32'h9, 32'h0, 0, 1'b0, 50);
        checks++;
        if (o_ack !== 2 || o_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_ack: ack=%0d err=%b want 2 1", o_ack, o_err);
        end
        checks++;
        if (o_adr !== 0 || o_dsn !== 0 || o_oe !== 0) begin
            errors++;
            $display("FAIL illegal_bus: adr=%0d dsn=%0d oe=%0d want 0 0 0", o_adr, o_dsn, o_oe);
        end
        checks++;
        if (o_rdata !== model_rdata) begin
            errors++;
            $display("FAIL illegal_rdata: got %h want %h", o_rdata, model_rdata);
        end
    endtask
    task automatic test_wait;
        int e_ack, e_dsn, e_oe;
        int acks;
        logic e_err;
        predict(4'b0000, 32'h0BAD_F00D, 10, e_ack, e_dsn, e_oe, e_err);
        drive_txn(4'b0000, 32'h300, 32'h0, 32'h0BAD_F00D, 10, 1'b0, 100);
        checks++;
        if (o_dsn !== e_dsn || o_ack !== e_ack) begin
            errors++;
            $display("FAIL wait_len: dsn=%0d ack=%0d want %0d %0d", o_dsn, o_ack, e_dsn, e_ack);
        end
        checks++;
        if (o_rdata !== model_rdata || o_err !== e_err) begin
            errors++;
            $display("FAIL wait_data: rdata=%h err=%b want %h %b", o_rdata, o_err, model_rdata, e_err);
        end
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL wait_single_ack: extra acks=%0d want 0", acks); end
    endtask
    task automatic test_back_to_back;
        int e_ack, e_dsn, e_oe;
        logic e_err;
        predict(4'b1111, 32'h0, 1, e_ack, e_dsn, e_oe, e_err);
        drive_txn(4'b1111, 32'h400, 32'hDEAD_BEEF, 32'h0, 1, 1'b1, 50);
        checks++;
        if (o_ack !== e_ack) begin errors++; $display("FAIL b2b_first: ack=%0d want %0d", o_ack, e_ack); end
        predict(4'b0000, 32'h1357_9BDF, 0, e_ack, e_dsn, e_oe, e_err);
        drive_txn(4'b0000, 32'h404, 32'h0, 32'h1357_9BDF, 0, 1'b0, 50);
        checks++;
        if (o_ack !== e_ack || o_addr !== 32'h404 || o_rdata !== model_rdata) begin
            errors++;
            $display("FAIL b2b_second: ack=%0d addr=%h rdata=%h want %0d 00000404 %h",
                     o_ack, o_addr, o_rdata, e_ack, model_rdata);
        end
    endtask
    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            logic [3:0]  s;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] ad;
            int          w;
            int          e_ack, e_dsn, e_oe;
            logic        e_err;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) s = 4'b0000;
            a = $urandom;
            d = $urandom;
            ad = $urandom;
            w = $urandom_range(0, 5);
            predict(s, ad, w, e_ack, e_dsn, e_oe, e_err);
            drive_txn(s, a, d, ad, w, $urandom_range(0, 1) == 1, 100);
            checks++;
            if (o_ack !== e_ack || o_err !== e_err || o_rdata !== model_rdata) begin
                errors++;
                $display("FAIL rand%0d_resp: s=%b w=%0d ack=%0d err=%b rdata=%h want %0d %b %h",
                         i, s, w, o_ack, o_err, o_rdata, e_ack, e_err, model_rdata);
            end
            checks++;
            if (o_adr !== (legal(s) ? AC : 0) || o_dsn !== e_dsn || o_oe !== e_oe || o_bad !== 0) begin
                errors++;
                $display("FAIL rand%0d_bus: s=%b adr=%0d dsn=%0d oe=%0d bad=%0d want %0d %0d %0d 0",
                         i, s, o_adr, o_dsn, o_oe, o_bad, legal(s) ? AC : 0, e_dsn, e_oe);
            end
            checks++;
            if (o_wr !== s || o_addr !== a || o_wdata !== d) begin
                errors++;
                $display("FAIL rand%0d_enc: wr=%b addr=%h wdata=%h want %b %h %h", i, o_wr, o_addr, o_wdata, s, a, d);
            end
        end
        cpu_req = 1'b0;
    endtask
    task automatic test_timeout;
`ifdef XIBUS_TIMEOUT_EN
        drive_txn(4'b0000, 32'h500, 32'h0, 32'h7777_7777, 1000, 1'b0, 50);
        model_rdata = '0;
        checks++;
        if (o_ack !== 1 + AC + 4 + 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_dsn !== 4) begin
            errors++;
            $display("FAIL timeout: ack=%0d err=%b rdata=%h dsn=%0d want %0d 1 00000000 4",
                     o_ack, o_err, o_rdata, o_dsn, 1 + AC + 4 + 1);
        end
`else
        drive_txn(4'b0000, 32'h500, 32'h0, 32'h7777_7777, 5000, 1'b1, 1000);
        checks++;
        if (o_ack !== -1 || dsn_o !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: ack_cycle=%0d dsn=%b want no ack and dsn 0", o_ack, dsn_o);
        end
        cpu_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_rdata = '0;
`endif
    endtask
    task automatic test_rst_mid;
        int acks;
        drive_txn(4'b1111, 32'h600, 32'hA5A5_A5A5, 32'h0, 50, 1'b1, 6);
        checks++;
        if (o_dsn !== 3 || o_ack !== -1) begin
            errors++;
            $display("FAIL rst_mid_setup: dsn=%0d ack=%0d want 3 -1", o_dsn, o_ack);
        end
        rst = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({adrcyn_o, dsn_o, bus_oe_o, cpu_ack, cpu_err} !== 5'b11000 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: ctrl=%b rdata=%h want 11000 00000000",
                     {adrcyn_o, dsn_o, bus_oe_o, cpu_ack, cpu_err}, cpu_rdata);
        end
        rst = 1'b0;
        model_rdata = '0;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpu_ack || !dsn_o) acks++;
        end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL rst_mid_quiet: activity=%0d want 0", acks); end
    endtask
    initial begin
        test_reset();
        test_read();
        test_write();
        test_illegal();
        test_wait();
        test_back_to_back();
        test_random();
        test_timeout();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
